key_conditioner: RTL
====================

Name: key_conditioner

Overview:
- Parametrised N-channel push-button front end for the board-level game tops.
- Per channel: 2-flop synchroniser, debounce, one-cycle press/release pulses.
- Channel-to-key routing is selectable at run time between two compile-time permutations, so the control-layout swap lives inside the block.
- Sits between KEY pins and game logic (frog movement, score) on the divided game clock.

Parameters:
N_KEYS, 4, number of channels (≥1)
DEBOUNCE_CYCLES, 4, consecutive enabled ticks of disagreement before level flips (≥1)
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed
MAP0, {3,2,1,0}, packed N_KEYS×$clog2(N_KEYS) indices; channel i samples keys_in[MAP0[i]] when map_sel=0
MAP1, {0,2,3,1}, same for map_sel=1
REPEAT_DELAY, 64, enabled ticks held before first auto-repeat (AUTO_REPEAT_EN only)
REPEAT_RATE, 16, enabled ticks between later repeats (AUTO_REPEAT_EN only)

Ports:
clk  in  1  game clock
reset  in  1  synchronous, active-low reset
enable  in  1  tick qualifier; debounce/repeat counters advance only when high
map_sel  in  1  selects MAP0 (0) or MAP1 (1)
keys_in  in  N_KEYS  raw pin inputs, asynchronous
level  out  N_KEYS  debounced state, 1 = pressed
press  out  N_KEYS  one-clk pulse on press (and repeats)
release  out  N_KEYS  one-clk pulse on release

Behaviour:
- Reset (reset=0 at clk edge): level, press, release = 0; counters = 0; sync flops load released value (1 if ACTIVE_LOW else 0). Reset wins over all other inputs.
- Routing: channel i raw = keys_in[MAPsel[i]], polarity-normalised to 1 = pressed, before the synchroniser. map_sel is not registered separately; a change is seen as an input change and debounced like one (no direct glitch on outputs).
- Synchroniser: two flops, clocked every clk regardless of enable.
- Debounce, per channel:
  - counter clears whenever synced == level.
  - On an enabled tick with synced != level: if count == DEBOUNCE_CYCLES-1, flip level and clear count; else count+1.
  - Ticks with enable=0 hold the count.
- Pulses, per channel:
  - press=1 for the single clk following the edge where level goes 0→1; release likewise for 1→0.
  - Pulses are one clk wide even if enable stays low afterwards.
- Latency with enable tied high: 2 + DEBOUNCE_CYCLES clk edges from keys_in change to level/pulse (6 at defaults).
- Bounce: any sample agreeing with level before the count completes restarts debounce; a bounce shorter than DEBOUNCE_CYCLES ticks produces no pulse.
- Channels are fully independent; simultaneous presses yield simultaneous pulses.
- Counter widths: $clog2 of the respective parameter + 1; no wrap is reachable.

Optional Feature:
AUTO_REPEAT_EN:
- Defined: per-channel hold counter runs on enabled ticks while level=1.
- press re-pulses (one clk) when the hold count reaches REPEAT_DELAY, then every REPEAT_RATE ticks after that.
- Hold counter clears on release or reset; a repeat never coincides with the initial press pulse.
- Undefined: no hold counters exist; press fires only on the 0→1 level edge.

Test Plan:
- Reset: hold reset=0 for 3 clk with keys_in=4'b0000 (ACTIVE_LOW) → level/press/release all 0; release reset with keys idle → outputs stay 0.
- Clean press: enable=1, map_sel=0, keys_in[3] 1→0 → press[0] high exactly one clk, 6 edges later; level[0]=1 until keys_in[3] returns high, then release[0] one-clk pulse 6 edges later.
- Bounce rejection: toggle keys_in[3] low 3 clk / high 1 clk / low 3 clk → no pulse at the first glitch; single press[0] 6 edges after the final low.
- Enable gating: enable high 1 clk in 4, DEBOUNCE_CYCLES=4 → level flips after 4 enabled ticks (~16 clk + 2 sync); press still one clk wide.
- Remap: map_sel=1, press keys_in[1] → press[3] pulses (MAP1[3]=1), press[0] stays 0; toggle map_sel while keys idle → no pulses.
- AUTO_REPEAT_EN defined: hold one key 200 enabled ticks → initial press, then repeats at ticks 64, 80, 96, …; release → repeats stop and a single release pulse fires.

Source files
------------

// File: rtl/key_conditioner_if.sv
// -----------------------------------------------------------------------------
// key_conditioner_if
//
// Groups the push-button front end's controls and its conditioned outputs so
// the board top and the game logic pass a single bundle around.
//
// Parameters:
//   N_KEYS        number of key channels; must match the key_conditioner instance
//
// Signals:
//   enable        tick qualifier for the debounce/repeat counters
//   map_sel       routing select, 0 = MAP0, 1 = MAP1
//   keys_in       raw, asynchronous pin levels
//   level         debounced state per channel, 1 = pressed
//   press         one-clk pulse when a channel becomes pressed (and on repeats)
//   release_pulse one-clk pulse when a channel becomes released
//                 (named this way because 'release' is a reserved word)
//
// Modports:
//   master        the side that drives the pins/controls and consumes the pulses
//   slave         the key_conditioner itself
// -----------------------------------------------------------------------------
interface key_conditioner_if #(
    parameter int N_KEYS = 4
);
    logic              enable;
    logic              map_sel;
    logic [N_KEYS-1:0] keys_in;
    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] release_pulse;

    modport master (
        output enable, map_sel, keys_in,
        input  level, press, release_pulse
    );

    modport slave (
        input  enable, map_sel, keys_in,
        output level, press, release_pulse
    );
endinterface

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// N-channel push-button front end: per-channel routing from the pins through
// one of two compile-time permutations, a 2-flop synchroniser, a counting
// debouncer and registered one-clk press/release pulses.
//
// Ports:
//   clk     game clock
//   reset   synchronous, active-low reset
//   keys    key_conditioner_if.slave (enable, map_sel, keys_in in;
//           level, press, release_pulse out)
//
// Routing tables: MAP0/MAP1 are packed N_KEYS x IDX_W index lists written
// left to right starting at channel 0, so the leftmost entry is the pin that
// channel 0 samples. Every entry must be a valid pin index (< N_KEYS).
//
// Optional feature (macro AUTO_REPEAT_EN): when defined, a held key re-fires
// press after REPEAT_DELAY enabled ticks and then every REPEAT_RATE ticks.
// When undefined no hold counters exist and press fires only on the 0->1 edge.
// -----------------------------------------------------------------------------
module key_conditioner #(
    parameter int   N_KEYS          = 4,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter bit   ACTIVE_LOW      = 1'b1,
    localparam int  IDX_W           = (N_KEYS > 1) ? $clog2(N_KEYS) : 1,
    parameter logic [N_KEYS*IDX_W-1:0] MAP0 = 8'b11_10_01_00,
    parameter logic [N_KEYS*IDX_W-1:0] MAP1 = 8'b00_10_11_01,
    parameter int   REPEAT_DELAY    = 64,
    parameter int   REPEAT_RATE     = 16
) (
    input logic              clk,
    input logic              reset,
    key_conditioner_if.slave keys
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    if (N_KEYS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("key_conditioner: N_KEYS, DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    // Pin index for channel ch; channel 0 is the leftmost (most significant) slot.
    function automatic logic [IDX_W-1:0] map_entry(input logic [N_KEYS*IDX_W-1:0] map, input int ch);
        return map[(N_KEYS-1-ch)*IDX_W +: IDX_W];
    endfunction

    logic [N_KEYS-1:0] routed;       // routed pins, still in pin polarity
    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] pressed_s;    // synchronised, 1 = pressed
    logic [N_KEYS-1:0] level_q;
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] release_q;
    logic [N_KEYS-1:0] flip;         // level toggles at this edge
    logic [N_KEYS-1:0] repeat_fire;  // auto-repeat press at this edge
    logic [CNT_W-1:0]  db_cnt [N_KEYS];

    // map_sel is deliberately not registered: switching tables just looks
    // like a pin change to the synchroniser and gets debounced like one.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first;
        // a path that skips an assignment would otherwise infer a latch.
        routed = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            routed[i] = keys.keys_in[keys.map_sel ? map_entry(MAP1, i) : map_entry(MAP0, i)];
        end
    end

    // The sync chain carries pin polarity so its reset value is the idle pin
    // level; normalising after the chain is a plain XOR and adds no delay.
    assign pressed_s = sync2 ^ {N_KEYS{ACTIVE_LOW}};

    always_comb begin
        flip = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            flip[i] = keys.enable && (pressed_s[i] != level_q[i])
                      && (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            sync1     <= {N_KEYS{ACTIVE_LOW}};
            sync2     <= {N_KEYS{ACTIVE_LOW}};
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            // NOTE: the per-channel counter array is real control state, not
            // storage, so every entry is cleared by reset like any register.
            for (int i = 0; i < N_KEYS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1     <= routed;
            sync2     <= sync1;
            level_q   <= level_q ^ flip;
            // Pulses are registered alongside the level flip, so they are one
            // clk wide independent of enable.
            press_q   <= (flip & ~level_q) | repeat_fire;
            release_q <= flip & level_q;
            for (int i = 0; i < N_KEYS; i++) begin
                if (pressed_s[i] == level_q[i]) begin
                    db_cnt[i] <= '0;           // agreement (or a bounce back) restarts debounce
                end else if (keys.enable) begin
                    if (flip[i]) begin
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

    logic [HOLD_W-1:0] hold_cnt [N_KEYS];
    logic [N_KEYS-1:0] in_rate;  // first repeat done, now spacing by REPEAT_RATE

    // Counting restarts from zero at the press edge, so the earliest repeat is
    // REPEAT_DELAY ticks after the initial pulse and never coincides with it.
    always_comb begin
        repeat_fire = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            repeat_fire[i] = keys.enable && level_q[i] && !flip[i]
                             && (hold_cnt[i] == (in_rate[i] ? HOLD_W'(REPEAT_RATE - 1)
                                                            : HOLD_W'(REPEAT_DELAY - 1)));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_rate <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (!level_q[i] || flip[i]) begin
                    hold_cnt[i] <= '0;
                    in_rate[i]  <= 1'b0;
                end else if (keys.enable) begin
                    if (repeat_fire[i]) begin
                        hold_cnt[i] <= '0;
                        in_rate[i]  <= 1'b1;
                    end else begin
                        hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
                    end
                end
            end
        end
    end
`else
    assign repeat_fire = '0;
`endif

    assign keys.level         = level_q;
    assign keys.press         = press_q;
    assign keys.release_pulse = release_q;

endmodule
